// File: rtl/uno_pkg.sv
// Shared types and Q5.10 coefficient tables for the uno_horner polynomial evaluator.
// Coefficients are stored lowest order first: index k holds c_k.
package uno_pkg;

  localparam int UNO_INT_BW = 5;
  localparam int UNO_FRA_BW = 10;
  localparam int UNO_MUL_BW = 1 + UNO_INT_BW + UNO_FRA_BW;
  localparam int UNO_TERMS  = 4;
  localparam int UNO_IDX_BW = 2;

  typedef enum logic [1:0] {
    UNO_GEMM = 2'b00,
    UNO_DIV  = 2'b01,
    UNO_EXP  = 2'b10,
    UNO_LOG  = 2'b11
  } uno_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } uno_state_e;

  typedef logic signed [UNO_MUL_BW-1:0] uno_word_t;

  // div: 4/3 * sum (4v/3)^k around x = 0.75
  localparam uno_word_t DIV_COEF [UNO_TERMS] = '{16'sd1365, 16'sd1820, 16'sd2427, 16'sd3236};
  localparam uno_word_t EXP_COEF [UNO_TERMS] = '{16'sd1024, 16'sd1024, 16'sd512, 16'sd171};
  // log: ln(0.75) + ln(1 - 4v/3)
  localparam uno_word_t LOG_COEF [UNO_TERMS] = '{-16'sd295, -16'sd1365, -16'sd910, -16'sd809};

  function automatic uno_word_t uno_coef(input uno_mode_e mode,
                                         input logic [UNO_IDX_BW-1:0] idx);
    uno_word_t c;
    c = '0;
    case (mode)
      UNO_DIV: c = DIV_COEF[idx];
      UNO_EXP: c = EXP_COEF[idx];
      UNO_LOG: c = LOG_COEF[idx];
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uno_mac_sat.sv
// Combinational Horner step: sat16(round(acc * v) + coef), all signed fixed point.
// Saturation is applied only to the final sum; the rounded product is kept wide.
module uno_mac_sat
  import uno_pkg::*;
#(
  parameter int MUL_BW = UNO_MUL_BW,
  parameter int FRA_BW = UNO_FRA_BW
) (
  input  logic signed [MUL_BW-1:0] acc_i,
  input  logic signed [MUL_BW-1:0] var_i,
  input  logic signed [MUL_BW-1:0] coef_i,
  output logic signed [MUL_BW-1:0] sum_o
);

  localparam int PROD_BW = 2 * MUL_BW;
  localparam int RND_BW  = 2 * MUL_BW - FRA_BW + 1;
  localparam int SUM_BW  = RND_BW + 1;

  localparam logic signed [SUM_BW-1:0] SAT_MAX = SUM_BW'((2 ** (MUL_BW - 1)) - 1);
  localparam logic signed [SUM_BW-1:0] SAT_MIN = -SUM_BW'(2 ** (MUL_BW - 1));
  localparam logic signed [PROD_BW-1:0] RND_HALF = PROD_BW'(1) << (FRA_BW - 1);

  logic signed [PROD_BW-1:0] prod;
  logic signed [PROD_BW-1:0] prod_rnd;
  logic signed [RND_BW-1:0]  rnd;
  logic signed [SUM_BW-1:0]  sum;

  always_comb begin
    prod     = $signed({{MUL_BW{acc_i[MUL_BW-1]}}, acc_i})
             * $signed({{MUL_BW{var_i[MUL_BW-1]}}, var_i});
    prod_rnd = prod + RND_HALF;
    // Round half up: bias then arithmetic shift.
    rnd      = RND_BW'(prod_rnd >>> FRA_BW);
    sum      = $signed({rnd[RND_BW-1], rnd})
             + $signed({{(SUM_BW - MUL_BW){coef_i[MUL_BW-1]}}, coef_i});
    if (sum > SAT_MAX) begin
      sum_o = SAT_MAX[MUL_BW-1:0];
    end else if (sum < SAT_MIN) begin
      sum_o = SAT_MIN[MUL_BW-1:0];
    end else begin
      sum_o = sum[MUL_BW-1:0];
    end
  end

endmodule

// File: rtl/uno_horner.sv
// Iterative Horner evaluator for the div/exp/log unary modes of the PE.
// One operand in flight: accept in IDLE, TERMS-1 steps in ITER, hold result in DONE.
module uno_horner
  import uno_pkg::*;
#(
  parameter int INT_BW = UNO_INT_BW,
  parameter int FRA_BW = UNO_FRA_BW,
  parameter int MUL_BW = 1 + INT_BW + FRA_BW,
  parameter int TERMS  = UNO_TERMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        gemm_uno,
  input  logic [MUL_BW-1:0] var_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MUL_BW-1:0] res_o
);

  uno_state_e               state_q, state_d;
  uno_mode_e                mode_q, mode_d;
  logic [MUL_BW-1:0]        var_q, var_d;
  logic [MUL_BW-1:0]        acc_q, acc_d;
  logic [UNO_IDX_BW-1:0]    cnt_q, cnt_d;

  uno_mode_e                mode_in;
  logic signed [MUL_BW-1:0] coef;
  logic signed [MUL_BW-1:0] step_sum;

  assign mode_in = uno_mode_e'(gemm_uno);
  assign coef    = uno_coef(mode_q, cnt_q);

  uno_mac_sat #(
    .MUL_BW (MUL_BW),
    .FRA_BW (FRA_BW)
  ) u_mac (
    .acc_i  ($signed(acc_q)),
    .var_i  ($signed(var_q)),
    .coef_i (coef),
    .sum_o  (step_sum)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    var_d     = var_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mode_d = mode_in;
          var_d  = var_i;
          if (mode_in == UNO_GEMM) begin
            acc_d   = '0;
            state_d = ST_DONE;
          end else begin
            acc_d   = uno_coef(mode_in, UNO_IDX_BW'(TERMS - 1));
            cnt_d   = UNO_IDX_BW'(TERMS - 2);
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        acc_d = step_sum;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= UNO_GEMM;
      var_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      var_q   <= var_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The accumulator is visible in every state; out_valid qualifies it.
  assign res_o = acc_q;

endmodule
